// File: rtl/spi_master_param_pkg.sv
// spi_master_param_pkg: shared FSM encoding and chip-select width helper
package spi_master_param_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL, ST_DONE} state_t;
  function automatic int cs_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_master_param_sclk_gen.sv
// spi_master_param_sclk_gen: half-period/edge counters, SCLK level and edge strobes
module spi_master_param_sclk_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_cpol,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_hp_end,
  output logic             o_lead_stb,
  output logic             o_trail_stb,
  output logic             o_last_edge,
  output logic             o_sclk
);
  localparam int E_W = $clog2(2*DATA_W) + 1;
  logic [DIV_W-1:0] r_hcnt;
  logic [E_W-1:0]   r_ecnt;
  logic             r_sclk;
  logic             w_edge;
  assign o_hp_end    = r_hcnt == i_div;
  assign w_edge      = i_shift && o_hp_end;
  assign o_lead_stb  = w_edge && !r_ecnt[0];
  assign o_trail_stb = w_edge && r_ecnt[0];
  assign o_last_edge = r_ecnt == E_W'(2*DATA_W-1);
  assign o_sclk      = r_sclk;
  // counters restart while idle so LEAD always gets a full half-period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hcnt <= '0;
      r_ecnt <= '0;
    end else if (i_load) begin
      r_hcnt <= '0;
      r_ecnt <= '0;
    end else begin
      r_hcnt <= o_hp_end ? '0 : r_hcnt + 1'b1;
      if (w_edge) r_ecnt <= r_ecnt + 1'b1;
    end
  // SCLK follows idle polarity when idle, toggles at each SHIFT half-period end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sclk <= 1'b0;
    else if (i_load) r_sclk <= i_cpol;
    else if (w_edge) r_sclk <= !r_sclk;
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with runtime mode, divider, bit order and chip select
module spi_master_param import spi_master_param_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 1
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      lsb_first,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic [cs_w(NUM_CS)-1:0]   cs_sel,
  input  logic                      miso,
  output logic                      sclk,
  output logic                      mosi,
  output logic [NUM_CS-1:0]         cs_n,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         data_out
);
  localparam int CS_W = cs_w(NUM_CS);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_tx, r_rx, r_dout;
  logic [DIV_W-1:0]  r_div;
  logic [CS_W-1:0]   r_cs_sel;
  logic              r_cpha, r_lsb, r_mosi;
  logic              w_idle, w_accept, w_hp_end, w_lead, w_trail, w_last, w_samp, w_shift;
  assign w_idle   = r_state == ST_IDLE || r_state == ST_DONE;
  assign w_accept = go && w_idle;
  assign w_samp   = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead : (w_trail && !w_last);
  assign mosi     = r_mosi;
  assign data_out = r_dout;
  spi_master_param_sclk_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_sclk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_idle),
    .i_shift     (r_state == ST_SHIFT),
    .i_cpol      (cpol),
    .i_div       (r_div),
    .o_hp_end    (w_hp_end),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_last_edge (w_last),
    .o_sclk      (sclk)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: DONE behaves like IDLE so a held go chains frames
  always_comb begin
    w_next = w_idle ? (go ? ST_LEAD : ST_IDLE) :
             (r_state == ST_LEAD)  ? (w_hp_end ? ST_SHIFT : ST_LEAD) :
             (r_state == ST_SHIFT) ? ((w_trail && w_last) ? ST_TRAIL : ST_SHIFT) :
             (w_hp_end ? ST_DONE : ST_TRAIL);
  end
  // status and one-hot-low chip select decode; out-of-range select drives none
  always_comb begin
    busy = !w_idle;
    done = r_state == ST_DONE;
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (!w_idle && r_cs_sel == CS_W'(i)) cs_n[i] = 1'b0;
  end
  // latch config on accept, then shift TX/RX on the strobed SCLK edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx     <= '0;
      r_rx     <= '0;
      r_dout   <= '0;
      r_div    <= '0;
      r_cs_sel <= '0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
      r_mosi   <= 1'b0;
    end else if (w_accept) begin
      r_tx     <= cpha ? data_in : (lsb_first ? data_in >> 1 : data_in << 1);
      r_mosi   <= !cpha && (lsb_first ? data_in[0] : data_in[DATA_W-1]);
      r_rx     <= '0;
      r_div    <= clk_div;
      r_cs_sel <= cs_sel;
      r_cpha   <= cpha;
      r_lsb    <= lsb_first;
    end else begin
      if (w_shift) begin
        r_mosi <= r_lsb ? r_tx[0] : r_tx[DATA_W-1];
        r_tx   <= r_lsb ? r_tx >> 1 : r_tx << 1;
      end
      if (w_samp) r_rx <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
      if (r_state == ST_TRAIL && w_hp_end) begin
        r_dout <= r_rx;
        r_mosi <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: vector table, randomized frames and corner sequences against an SPI slave model
module tb_spi_master_param;
  logic       clk = 0, rst_n = 0, go = 0, cpol = 0, cpha = 0, lsb = 0, s_miso = 0, lb = 0;
  logic [7:0] din = 0, cdiv = 0;
  logic [1:0] sel = 0;
  logic       sclk, mosi, busy, done, miso;
  logic [2:0] cs_n;
  logic [7:0] dout;
  logic [7:0] s_tx = 0, s_rx = 0;
  logic       s_cpha = 0, s_lsb = 0;
  int         s_n = 0, n_rise = 0, n_done = 0, nchk = 0, nerr = 0;

  typedef struct {
    logic       cpol, cpha, lsb, lb;
    logic [7:0] div, data, slv;
    logic [1:0] sel;
    logic [7:0] exp_dout;
    int         exp_lat;
  } vec_t;
  vec_t tbl[5];

  assign miso = lb ? mosi : s_miso;
  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_CS(3)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .data_in(din), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb), .clk_div(cdiv), .cs_sel(sel), .miso(miso), .sclk(sclk),
    .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .data_out(dout)
  );

  // SPI slave: presents its word on shift edges, captures mosi on sample edges
  always @(posedge busy) begin
    s_n = 0; s_rx = 0; s_cpha = cpha; s_lsb = lsb;
    s_miso = cpha ? 1'b0 : (lsb ? s_tx[0] : s_tx[7]);
  end
  always @(sclk) if (busy) begin
    int k;
    s_n++;
    if ((s_n % 2 == 1) != s_cpha) begin
      k = (s_n - 1) / 2;
      s_rx[s_lsb ? k : 7 - k] = mosi;
    end else if (s_n / 2 < 8) begin
      k = s_n / 2;
      s_miso = s_tx[s_lsb ? k : 7 - k];
    end
  end
  always @(posedge sclk) if (busy) n_rise++;
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input vec_t v);
    int c; bit cs_ok; logic [2:0] ecs;
    ecs = (v.sel < 3) ? ~(3'b001 << v.sel) : 3'b111;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; lsb = v.lsb; cdiv = v.div; sel = v.sel;
    din = v.data; lb = v.lb; s_tx = v.slv;
    @(negedge clk); n_rise = 0; go = 1;
    @(negedge clk); go = 0; c = 1; cs_ok = 1;
    while (done !== 1'b1 && c < 2000) begin
      if (cs_n !== ecs || busy !== 1'b1) cs_ok = 0;
      @(negedge clk); c++;
    end
    chk("latency", c, v.exp_lat);
    chk("data_out", dout, v.exp_dout);
    chk("slave_rx", s_rx, v.data);
    chk("cs_busy_during", cs_ok, 1);
    chk("sclk_rises", n_rise, 8);
    chk("sclk_idle", sclk, v.cpol);
    chk("done_state", {busy, cs_n}, 4'b0111);
    @(negedge clk); chk("done_pulse", done, 0);
  endtask

  initial begin
    int c, d0; logic [2:0] pcs; vec_t v;
    tbl[0] = '{cpol:0, cpha:0, lsb:0, lb:1, div:0, data:8'hA5, slv:8'h00, sel:0, exp_dout:8'hA5, exp_lat:19};
    tbl[1] = '{cpol:1, cpha:1, lsb:0, lb:0, div:3, data:8'hC3, slv:8'h3C, sel:0, exp_dout:8'h3C, exp_lat:73};
    tbl[2] = '{cpol:0, cpha:1, lsb:1, lb:0, div:1, data:8'h01, slv:8'h80, sel:1, exp_dout:8'h80, exp_lat:37};
    tbl[3] = '{cpol:0, cpha:0, lsb:0, lb:0, div:0, data:8'h5A, slv:8'h96, sel:2, exp_dout:8'h96, exp_lat:19};
    tbl[4] = '{cpol:1, cpha:0, lsb:1, lb:0, div:2, data:8'h3E, slv:8'h71, sel:3, exp_dout:8'h71, exp_lat:55};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 3'b111);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", dout, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) run(tbl[i]);
    for (int i = 0; i < 24; i++) begin
      v.cpol = 1'($urandom); v.cpha = 1'($urandom); v.lsb = 1'($urandom); v.lb = 1'($urandom);
      v.div = 8'($urandom_range(0, 3)); v.data = 8'($urandom); v.slv = 8'($urandom);
      v.sel = 2'($urandom);
      v.exp_dout = v.lb ? v.data : v.slv;
      v.exp_lat = 1 + (2 * 8 + 2) * (int'(v.div) + 1);
      run(v);
    end
    // go held across done chains a second frame; data_in change while busy is ignored
    @(negedge clk); cpol = 0; cpha = 0; lsb = 0; cdiv = 0; sel = 1; lb = 1; din = 8'h69;
    @(negedge clk); go = 1; d0 = n_done;
    @(negedge clk); din = 8'hD2; c = 1; pcs = cs_n;
    while (done !== 1'b1 && c < 2000) begin pcs = cs_n; @(negedge clk); c++; end
    chk("b2b_lat1", c, 19);
    chk("b2b_dout1", dout, 8'h69);
    chk("b2b_cs_before", pcs, 3'b101);
    chk("b2b_cs_gap", cs_n, 3'b111);
    @(negedge clk); chk("b2b_lead2", {busy, cs_n}, 4'b1101); go = 0;
    repeat (4) @(negedge clk);
    go = 1; @(negedge clk); go = 0;
    wait_done(c);
    chk("b2b_lat2", c, 13);
    chk("b2b_dout2", dout, 8'hD2);
    repeat (60) @(negedge clk);
    chk("b2b_done_pulses", n_done - d0, 2);
    // reset mid-frame aborts cleanly, the following frame is unaffected
    @(negedge clk); cpol = 0; cpha = 0; lsb = 0; cdiv = 0; sel = 0; lb = 0; din = 8'h81; s_tx = 8'hFF;
    @(negedge clk); go = 1;
    @(negedge clk); go = 0; c = 0;
    while (s_n < 5 && c < 200) begin @(negedge clk); c++; end
    chk("abort_reach_edge5", s_n >= 5, 1);
    rst_n = 0; #1;
    chk("abort_cs_n", cs_n, 3'b111);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data_out", dout, 0);
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    v = '{cpol:0, cpha:0, lsb:0, lb:0, div:0, data:8'h81, slv:8'h7E, sel:0, exp_dout:8'h7E, exp_lat:19};
    run(v);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
